// File: rtl/spi_cmd_controller.sv
// Purpose : decode SPI command bytes into per-frame movement requests and speed/turn config registers.
// Latency : opcode->pending 1 cycle; pending->o_move_cmd at next frame_start +1; operand->config 1 cycle.
// Backpres: none; every i_rx_valid strobe is consumed in the cycle it arrives (no stall path to the SPI slave).
//
// Ports
//   i_clk, i_rst          : system clock, synchronous active-high reset
//   i_rx_valid, i_rx_byte : one-cycle strobe plus the received byte
//   i_cs_active           : synchronised chip-select (high = CS asserted)
//   i_frame_start         : one-cycle pulse at the start of vertical blanking
//   o_move_cmd            : committed movement {turn_right, turn_left, back, fwd}, held for the frame
//   o_move_valid          : one-cycle pulse the cycle after a commit
//   o_speed, o_turn_rate  : configuration registers
//   o_cmd_err_cnt         : saturating count of unknown opcodes and aborted operand waits
//   o_busy                : high while an operand byte is awaited
//   o_status_byte         : {busy, err_sat, 2'b00, pending}; present only with SPI_CMD_STATUS_EN defined
//
// Optional feature macro: SPI_CMD_STATUS_EN

module spi_cmd_controller #(
    parameter logic [7:0] SPEED_RST = 8'd4,
    parameter logic [7:0] TURN_RST  = 8'd2,
    parameter int         ERR_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_byte,
    input  logic             i_cs_active,
    input  logic             i_frame_start,
    output logic [3:0]       o_move_cmd,
    output logic             o_move_valid,
    output logic [7:0]       o_speed,
    output logic [7:0]       o_turn_rate,
    output logic [ERR_W-1:0] o_cmd_err_cnt,
    output logic             o_busy
`ifdef SPI_CMD_STATUS_EN
    ,
    output logic [7:0]       o_status_byte
`endif
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_FWD       = 8'h01;
    localparam logic [7:0] OP_BACK      = 8'h02;
    localparam logic [7:0] OP_LEFT      = 8'h03;
    localparam logic [7:0] OP_RIGHT     = 8'h04;
    localparam logic [7:0] OP_SET_SPEED = 8'h10;
    localparam logic [7:0] OP_SET_TURN  = 8'h11;

    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    typedef enum logic {
        ST_IDLE         = 1'b0,
        ST_WAIT_OPERAND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_op_is_turn;   // latched opcode: 0 = SET_SPEED, 1 = SET_TURN
    logic [3:0]       r_pending;      // {right, left, back, fwd} requested this frame
    logic [3:0]       r_move_cmd;
    logic             r_move_valid;
    logic [7:0]       r_speed;
    logic [7:0]       r_turn_rate;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_busy;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    state_t     w_state_nxt;
    logic [3:0] w_set_bits;      // pending bit requested by this cycle's opcode
    logic       w_err_evt;       // bad opcode or aborted operand wait
    logic       w_latch_op;
    logic       w_op_turn_nxt;
    logic       w_wr_speed;
    logic       w_wr_turn;

    always_comb begin
        w_state_nxt   = r_state;
        w_set_bits    = 4'b0000;
        w_err_evt     = 1'b0;
        w_latch_op    = 1'b0;
        w_op_turn_nxt = r_op_is_turn;
        w_wr_speed    = 1'b0;
        w_wr_turn     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Chip-select is deliberately ignored here: only an
                // operand wait can be aborted.
                if (i_rx_valid) begin
                    case (i_rx_byte)
                        OP_NOP: begin
                            w_set_bits = 4'b0000;
                        end
                        OP_FWD:   w_set_bits = 4'b0001;
                        OP_BACK:  w_set_bits = 4'b0010;
                        OP_LEFT:  w_set_bits = 4'b0100;
                        OP_RIGHT: w_set_bits = 4'b1000;
                        OP_SET_SPEED: begin
                            w_state_nxt   = ST_WAIT_OPERAND;
                            w_latch_op    = 1'b1;
                            w_op_turn_nxt = 1'b0;
                        end
                        OP_SET_TURN: begin
                            w_state_nxt   = ST_WAIT_OPERAND;
                            w_latch_op    = 1'b1;
                            w_op_turn_nxt = 1'b1;
                        end
                        default: begin
                            w_err_evt = 1'b1;
                        end
                    endcase
                end
            end

            ST_WAIT_OPERAND: begin
                // A byte that completes in the same cycle CS drops is still
                // a full operand, so it takes priority over the abort.
                if (i_rx_valid) begin
                    w_state_nxt = ST_IDLE;
                    if (r_op_is_turn) begin
                        w_wr_turn = 1'b1;
                    end else begin
                        w_wr_speed = 1'b1;
                    end
                end else if (!i_cs_active) begin
                    w_state_nxt = ST_IDLE;
                    w_err_evt   = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Commit path
    // ------------------------------------------------------------------
    // Opposing requests in the same frame cancel each other rather than
    // letting one direction win arbitrarily.
    logic [3:0] w_resolved;
    logic [3:0] w_pending_nxt;
    logic       w_err_sat;

    always_comb begin
        w_resolved = r_pending;
        if (r_pending[0] && r_pending[1]) begin
            w_resolved[1:0] = 2'b00;
        end
        if (r_pending[2] && r_pending[3]) begin
            w_resolved[3:2] = 2'b00;
        end
    end

    // On a commit the old pending goes to o_move_cmd and is cleared; a
    // request arriving on that same edge lands in the cleared vector so it
    // carries into the next frame instead of being dropped.
    assign w_pending_nxt = (i_frame_start ? 4'b0000 : r_pending) | w_set_bits;
    assign w_err_sat     = &r_err_cnt;

    // ------------------------------------------------------------------
    // State register (reset overrides every other event, including an
    // operand arriving in the same cycle)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_is_turn <= 1'b0;
            r_pending    <= 4'b0000;
            r_move_cmd   <= 4'b0000;
            r_move_valid <= 1'b0;
            r_speed      <= SPEED_RST;
            r_turn_rate  <= TURN_RST;
            r_err_cnt    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_move_valid <= i_frame_start;
            r_busy       <= (w_state_nxt == ST_WAIT_OPERAND);

            if (w_latch_op) begin
                r_op_is_turn <= w_op_turn_nxt;
            end
            if (i_frame_start) begin
                r_move_cmd <= w_resolved;
            end
            if (w_wr_speed) begin
                r_speed <= i_rx_byte;
            end
            if (w_wr_turn) begin
                r_turn_rate <= i_rx_byte;
            end
            // Saturate at all-ones so a flood of garbage never looks clean.
            if (w_err_evt && !w_err_sat) begin
                r_err_cnt <= r_err_cnt + ERR_ONE;
            end
        end
    end

    assign o_move_cmd    = r_move_cmd;
    assign o_move_valid  = r_move_valid;
    assign o_speed       = r_speed;
    assign o_turn_rate   = r_turn_rate;
    assign o_cmd_err_cnt = r_err_cnt;
    assign o_busy        = r_busy;

`ifdef SPI_CMD_STATUS_EN
    // ------------------------------------------------------------------
    // Status byte, shifted back to the host on MISO next transfer
    // ------------------------------------------------------------------
    logic [7:0] r_status_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_status_byte <= 8'h00;
        end else begin
            r_status_byte <= {r_busy, w_err_sat, 2'b00, r_pending};
        end
    end

    assign o_status_byte = r_status_byte;
`endif

endmodule
